// File: rtl/pc_quantum_sched.sv
// rtl/pc_quantum_sched.sv - program counter with quantum-timer preemption to the OS entry
module pc_quantum_sched #(
  parameter int PC_W     = 32,
  parameter int Q_W      = 16,
  parameter int OS_LIMIT = 687,
  parameter int OS_ENTRY = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             stall,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             q_load,
  input  logic [Q_W-1:0]   q_value,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  saved_pc,
  output logic             preempt,
  output logic             halted,
  output logic             in_user,
  output logic [CNT_W-1:0] preempt_cnt
);

  localparam logic [PC_W-1:0] OS_LIM = PC_W'(OS_LIMIT);
  localparam logic [PC_W-1:0] OS_ENT = PC_W'(OS_ENTRY);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state, state_n;
  logic [Q_W-1:0]   q_limit, q_limit_n;
  logic [Q_W-1:0]   q_count, q_count_n;
  logic [PC_W-1:0]  pc_n, saved_n;
  logic             preempt_n, in_user_n;
  logic [CNT_W-1:0] cnt_n;
  logic             target_user, quantum_on, preempt_due;

  assign target_user = (pc_in >= OS_LIM);
  assign quantum_on  = (q_limit != '0);
  // Quantum exhausted: the next non-stalled advance is redirected to the OS.
  assign preempt_due = in_user && quantum_on && (q_count == q_limit);
  assign halted      = (state == HALT);

  always_comb begin
    state_n   = state;
    pc_n      = pc_out;
    saved_n   = saved_pc;
    q_limit_n = q_limit;
    q_count_n = q_count;
    preempt_n = 1'b0;
    in_user_n = in_user;
    cnt_n     = preempt_cnt;
    case (state)
      RUN: begin
        if (halt) begin
          state_n   = HALT;
          q_count_n = '0;
        end else begin
          if (preempt_due && !stall) begin
            saved_n   = pc_in;
            pc_n      = OS_ENT;
            q_count_n = '0;
            in_user_n = 1'b0;
            preempt_n = 1'b1;
            cnt_n     = preempt_cnt + CNT_W'(1);
          end else if (!stall) begin
            pc_n      = pc_in;
            in_user_n = target_user;
            // A user->OS jump (syscall) restarts the quantum without preempting.
            if (in_user && quantum_on && target_user)
              q_count_n = q_count + Q_W'(1);
            else
              q_count_n = '0;
          end
          if (q_load) begin
            q_limit_n = q_value;
            q_count_n = '0;
          end
        end
      end
      HALT: begin
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc_out      <= OS_ENT;
      saved_pc    <= '0;
      q_limit     <= '0;
      q_count     <= '0;
      preempt     <= 1'b0;
      in_user     <= 1'b0;
      preempt_cnt <= '0;
    end else begin
      state       <= state_n;
      pc_out      <= pc_n;
      saved_pc    <= saved_n;
      q_limit     <= q_limit_n;
      q_count     <= q_count_n;
      preempt     <= preempt_n;
      in_user     <= in_user_n;
      preempt_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pc_quantum_sched.sv
// tb/tb_pc_quantum_sched.sv - directed and randomized bench for pc_quantum_sched
module tb_pc_quantum_sched;

  localparam int OS_LIMIT = 687;

  logic        clk = 1'b0;
  logic        reset, halt, stall, q_load;
  logic [31:0] pc_in;
  logic [15:0] q_value;
  logic [31:0] pc_out, saved_pc;
  logic        preempt, halted, in_user;
  logic [7:0]  preempt_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: user instructions retired in the current quantum and bookkeeping.
  logic [31:0] m_pc, m_saved;
  int          m_limit, m_used, m_cnt;
  bit          m_halted, m_user, m_pre;

  pc_quantum_sched dut (
    .clk(clk), .reset(reset), .halt(halt), .stall(stall), .pc_in(pc_in),
    .q_load(q_load), .q_value(q_value), .pc_out(pc_out), .saved_pc(saved_pc),
    .preempt(preempt), .halted(halted), .in_user(in_user), .preempt_cnt(preempt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit to_user;
    to_user = (pc_in >= OS_LIMIT);
    if (reset) begin
      m_pc = 0; m_saved = 0; m_limit = 0; m_used = 0; m_cnt = 0;
      m_halted = 0; m_user = 0; m_pre = 0;
    end else if (m_halted) begin
      m_pre = 0;
    end else if (halt) begin
      m_halted = 1; m_used = 0; m_pre = 0;
    end else begin
      if (m_user && m_limit != 0 && m_used == m_limit && !stall) begin
        m_saved = pc_in; m_pc = OS_LIMIT - OS_LIMIT; m_used = 0;
        m_user = 0; m_pre = 1; m_cnt = (m_cnt + 1) % 256;
      end else if (stall) begin
        m_pre = 0;
      end else begin
        m_used = (m_user && m_limit != 0 && to_user) ? m_used + 1 : 0;
        m_pc = pc_in; m_user = to_user; m_pre = 0;
      end
      if (q_load) begin
        m_limit = q_value; m_used = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc_out", pc_out, m_pc);
    check("saved_pc", saved_pc, m_saved);
    check("preempt", 32'(preempt), 32'(m_pre));
    check("halted", 32'(halted), 32'(m_halted));
    check("in_user", 32'(in_user), 32'(m_user));
    check("preempt_cnt", 32'(preempt_cnt), 32'(m_cnt));
  endtask

  task automatic go(input logic [31:0] pc);
    pc_in = pc;
    step();
  endtask

  initial begin
    reset = 1; halt = 0; stall = 0; q_load = 0; q_value = 0; pc_in = 0;
    m_pc = 0; m_saved = 0; m_limit = 0; m_used = 0; m_cnt = 0;
    m_halted = 0; m_user = 0; m_pre = 0;
    #2;
    step(); step();
    check("rst_pc", pc_out, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_preempt", 32'(preempt), 0);
    check("rst_cnt", 32'(preempt_cnt), 0);
    check("rst_saved", saved_pc, 0);
    reset = 0;

    // Basic quantum of 3.
    q_load = 1; q_value = 3; go(700); q_load = 0;
    go(701); go(702); go(703);
    check("t2_pc703", pc_out, 703);
    go(704);
    check("t2_pc_os", pc_out, 0);
    check("t2_preempt", 32'(preempt), 1);
    check("t2_saved", saved_pc, 704);
    check("t2_cnt", 32'(preempt_cnt), 1);
    go(1);
    check("t2_pulse_end", 32'(preempt), 0);

    // Stall holds the PC and delays the preemption.
    go(700); go(701);
    stall = 1; pc_in = 702; step(); step();
    check("t3_hold", pc_out, 701);
    stall = 0;
    go(702); go(703);
    check("t3_no_early", 32'(preempt), 0);
    go(704);
    check("t3_preempt", 32'(preempt), 1);
    check("t3_saved", saved_pc, 704);

    // Syscall jump clears the count; re-entry gets a full quantum of 5.
    q_load = 1; q_value = 5; go(800); q_load = 0;
    go(801); go(802); go(10);
    check("t4_jump", pc_out, 10);
    check("t4_no_pre", 32'(preempt), 0);
    for (int i = 0; i < 6; i++) go(32'(900 + i));
    check("t4_full_q", pc_out, 905);
    check("t4_still_no_pre", 32'(preempt), 0);
    go(906);
    check("t4_preempt", 32'(preempt), 1);
    check("t4_saved", saved_pc, 906);

    // Halt is sticky until reset.
    go(750);
    halt = 1; step(); halt = 0;
    for (int i = 0; i < 5; i++) begin
      q_load = i[0]; q_value = 16'(i); go(32'(760 + i));
    end
    q_load = 0;
    check("t5_pc", pc_out, 750);
    check("t5_halted", 32'(halted), 1);
    reset = 1; step(); reset = 0;
    check("t5_rst_pc", pc_out, 0);
    check("t5_rst_halted", 32'(halted), 0);

    // Disabled quantum, then q_load coinciding with a preemption.
    q_load = 1; q_value = 0; go(1000); q_load = 0;
    for (int i = 1; i < 1000; i++) go(32'(1000 + i));
    check("t6_no_pre", 32'(preempt_cnt), 0);
    q_load = 1; q_value = 2; go(2000); q_load = 0;
    go(2001); go(2002);
    q_load = 1; q_value = 1; go(2003); q_load = 0;
    check("t6_pre_load", 32'(preempt), 1);
    go(800); go(801); go(802);
    check("t6_new_q", 32'(preempt), 1);
    check("t6_cnt", 32'(preempt_cnt), 2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset  = ($urandom_range(99) == 0);
      halt   = ($urandom_range(299) == 0);
      stall  = ($urandom_range(4) == 0);
      q_load = ($urandom_range(19) == 0);
      q_value = 16'($urandom_range(4));
      r = $urandom_range(9);
      if (r < 7)      pc_in = m_pc + 1;
      else if (r < 8) pc_in = $urandom_range(OS_LIMIT - 1);
      else if (r < 9) pc_in = $urandom_range(OS_LIMIT + 3, OS_LIMIT - 3);
      else            pc_in = $urandom_range(5000, OS_LIMIT);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
